button_input_controller: RTL and testbench

//  Front end of the game: turns raw DE2 push-buttons (KEY, active-low) into clean, one-shot game

---
 rtl/blackjack_pkg.sv | 26 ++
 rtl/button_input_controller_if.sv | 15 +
 rtl/button_debouncer.sv | 47 ++++
 rtl/button_input_controller.sv | 80 ++++++++
 tb/tb_button_input_controller.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/blackjack_pkg.sv
// Shared blackjack definitions: player command codes, command-register states, priority helper.
package blackjack_pkg;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_NONE  = 2'd0;
    localparam cmd_t CMD_HIT   = 2'd1;
    localparam cmd_t CMD_STAND = 2'd2;
    localparam cmd_t CMD_DEAL  = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } cmd_state_t;

    // ev is {deal, stand, hit}; DEAL beats STAND beats HIT.
    function automatic cmd_t prio_cmd(input logic [2:0] ev);
        cmd_t c;
        if (ev[2])      c = CMD_DEAL;
        else if (ev[1]) c = CMD_STAND;
        else if (ev[0]) c = CMD_HIT;
        else            c = CMD_NONE;
        return c;
    endfunction

endpackage

// File: rtl/button_input_controller_if.sv
// Command handshake from the button front end to the game FSM, plus debounced button levels.
interface button_input_controller_if;
    import blackjack_pkg::*;

    cmd_t       cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dropped;
    logic [2:0] buttons_held;

    modport master (output cmd, output cmd_valid, output cmd_dropped, output buttons_held,
                    input cmd_ready);
    modport slave  (input cmd, input cmd_valid, input cmd_dropped, input buttons_held,
                    output cmd_ready);
endinterface

// File: rtl/button_debouncer.sv
// One push-button: 2-flop sync, counter debounce, registered press pulse.
// Press pulse appears DEBOUNCE_CYCLES+3 edges after the raw key first reads low; releases give no pulse.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          synced;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1       <= 1'b1;
            synced      <= 1'b1;
            stable      <= 1'b1;
            stable_d    <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1       <= key_n;
            synced      <= sync1;
            stable_d    <= stable;
            press_pulse <= stable_d & ~stable;
            // The edge that completes the run of DEBOUNCE_CYCLES mismatches commits the new level.
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign level = ~stable;

endmodule

// File: rtl/button_input_controller.sv
// Three debounced buttons feed a priority encoder and a one-entry command register with valid/ready.
// Command valid one edge after a press pulse; events arriving while a command is pending and not accepted are dropped.
module button_input_controller
    import blackjack_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       key_hit_n,
    input  logic                       key_stand_n,
    input  logic                       key_deal_n,
    button_input_controller_if.master  bus
);
    logic [2:0] level;
    logic [2:0] ev;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hit (
        .clk(clk), .reset(reset), .key_n(key_hit_n), .level(level[0]), .press_pulse(ev[0])
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stand (
        .clk(clk), .reset(reset), .key_n(key_stand_n), .level(level[1]), .press_pulse(ev[1])
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deal (
        .clk(clk), .reset(reset), .key_n(key_deal_n), .level(level[2]), .press_pulse(ev[2])
    );

    cmd_state_t state_q, state_d;
    cmd_t       cmd_q, cmd_d;
    logic       dropped_q, dropped_d;
    logic       any_ev;
    logic       multi_ev;

    assign any_ev   = |ev;
    assign multi_ev = (ev & (ev - 3'd1)) != 3'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cmd_q     <= CMD_NONE;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        dropped_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (any_ev) begin
                state_d   = ST_PENDING;
                cmd_d     = prio_cmd(ev);
                dropped_d = multi_ev;
            end
        end else if (bus.cmd_ready) begin
            // Accept edge: a same-cycle event refills the register without a bubble.
            if (any_ev) begin
                cmd_d     = prio_cmd(ev);
                dropped_d = multi_ev;
            end else begin
                state_d = ST_IDLE;
                cmd_d   = CMD_NONE;
            end
        end else begin
            dropped_d = any_ev;
        end
    end

    always_comb begin
        bus.cmd          = cmd_q;
        bus.cmd_valid    = (state_q == ST_PENDING);
        bus.cmd_dropped  = dropped_q;
        bus.buttons_held = level;
    end

endmodule

// File: tb/tb_button_input_controller.sv
// Directed bench for button_input_controller with a 4-cycle debounce window.
module tb_button_input_controller;
    import blackjack_pkg::*;

    logic clk;
    logic reset;
    logic key_hit_n;
    logic key_stand_n;
    logic key_deal_n;
    int   total;
    int   bad;

    button_input_controller_if bus ();

    button_input_controller #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .key_hit_n(key_hit_n),
        .key_stand_n(key_stand_n),
        .key_deal_n(key_deal_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        key_hit_n = 1'b1; key_stand_n = 1'b1; key_deal_n = 1'b1;
        bus.cmd_ready = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; key_hit_n = 1'b1; key_stand_n = 1'b1; key_deal_n = 1'b1;
        bus.cmd_ready = 1'b0;
        #1;
        total++; if (bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.cmd_valid); end
        total++; if (bus.cmd !== CMD_NONE) begin bad++; $display("FAIL reset_cmd got=%0d want=%0d", bus.cmd, CMD_NONE); end
        total++; if (bus.cmd_dropped !== 1'b0) begin bad++; $display("FAIL reset_dropped got=%b want=0", bus.cmd_dropped); end
        total++; if (bus.buttons_held !== 3'b000) begin bad++; $display("FAIL reset_held got=%b want=000", bus.buttons_held); end
        tick(); tick();
        reset = 1'b0;
        repeat (3) tick();
        total++; if (bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", bus.cmd_valid); end
    endtask

    task automatic test_hit_hold();
        int errs;
        errs = 0;
        key_hit_n = 1'b0;
        repeat (7) tick();
        total++; if (bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL hit_early got=%b want=0", bus.cmd_valid); end
        tick();
        total++; if (bus.cmd_valid !== 1'b1) begin bad++; $display("FAIL hit_valid got=%b want=1", bus.cmd_valid); end
        total++; if (bus.cmd !== CMD_HIT) begin bad++; $display("FAIL hit_cmd got=%0d want=%0d", bus.cmd, CMD_HIT); end
        total++; if (bus.buttons_held !== 3'b001) begin bad++; $display("FAIL hit_held got=%b want=001", bus.buttons_held); end
        for (int i = 0; i < 22; i++) begin
            if (i == 12) key_hit_n = 1'b1;
            tick();
            if (bus.cmd_valid !== 1'b1 || bus.cmd !== CMD_HIT) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL hit_hold_pending bad_cycles=%0d want=0", errs); end
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        total++; if (bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL hit_accept_valid got=%b want=0", bus.cmd_valid); end
        total++; if (bus.cmd !== CMD_NONE) begin bad++; $display("FAIL hit_accept_cmd got=%0d want=%0d", bus.cmd, CMD_NONE); end
        errs = 0;
        repeat (10) begin tick(); if (bus.cmd_valid !== 1'b0) errs++; end
        total++; if (errs !== 0) begin bad++; $display("FAIL hit_one_event extra_valid_cycles=%0d want=0", errs); end
        settle();
    endtask

    task automatic test_bounce();
        int held_errs;
        int valid_errs;
        held_errs = 0; valid_errs = 0;
        for (int i = 0; i < 24; i++) begin
            key_hit_n = (i < 3 || (i >= 5 && i < 8)) ? 1'b0 : 1'b1;
            tick();
            if (bus.buttons_held !== 3'b000) held_errs++;
            if (bus.cmd_valid !== 1'b0) valid_errs++;
        end
        total++; if (held_errs !== 0) begin bad++; $display("FAIL bounce_held bad_cycles=%0d want=0", held_errs); end
        total++; if (valid_errs !== 0) begin bad++; $display("FAIL bounce_valid bad_cycles=%0d want=0", valid_errs); end
        settle();
    endtask

    task automatic test_simultaneous();
        int errs;
        errs = 0;
        key_deal_n = 1'b0; key_hit_n = 1'b0;
        repeat (8) tick();
        total++; if (bus.cmd_valid !== 1'b1) begin bad++; $display("FAIL simul_valid got=%b want=1", bus.cmd_valid); end
        total++; if (bus.cmd !== CMD_DEAL) begin bad++; $display("FAIL simul_cmd got=%0d want=%0d", bus.cmd, CMD_DEAL); end
        total++; if (bus.cmd_dropped !== 1'b1) begin bad++; $display("FAIL simul_drop got=%b want=1", bus.cmd_dropped); end
        tick();
        total++; if (bus.cmd_dropped !== 1'b0) begin bad++; $display("FAIL simul_drop_end got=%b want=0", bus.cmd_dropped); end
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        total++; if (bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL simul_accept got=%b want=0", bus.cmd_valid); end
        repeat (12) begin tick(); if (bus.cmd_valid !== 1'b0) errs++; end
        total++; if (errs !== 0) begin bad++; $display("FAIL simul_no_late_hit bad_cycles=%0d want=0", errs); end
        settle();
    endtask

    task automatic test_pending_drop();
        key_stand_n = 1'b0;
        repeat (8) tick();
        total++; if (bus.cmd !== CMD_STAND) begin bad++; $display("FAIL pend_cmd got=%0d want=%0d", bus.cmd, CMD_STAND); end
        key_stand_n = 1'b1; key_hit_n = 1'b0;
        repeat (8) tick();
        total++; if (bus.cmd_dropped !== 1'b1) begin bad++; $display("FAIL pend_drop got=%b want=1", bus.cmd_dropped); end
        total++; if (bus.cmd !== CMD_STAND) begin bad++; $display("FAIL pend_cmd_kept got=%0d want=%0d", bus.cmd, CMD_STAND); end
        tick();
        total++; if (bus.cmd_dropped !== 1'b0) begin bad++; $display("FAIL pend_drop_end got=%b want=0", bus.cmd_dropped); end
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        total++; if (bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL pend_accept got=%b want=0", bus.cmd_valid); end
        settle();
    endtask

    task automatic test_back_to_back();
        key_hit_n = 1'b0;
        repeat (8) tick();
        total++; if (bus.cmd !== CMD_HIT) begin bad++; $display("FAIL b2b_first got=%0d want=%0d", bus.cmd, CMD_HIT); end
        key_hit_n = 1'b1; key_stand_n = 1'b0;
        repeat (7) tick();
        total++; if (bus.cmd !== CMD_HIT) begin bad++; $display("FAIL b2b_before got=%0d want=%0d", bus.cmd, CMD_HIT); end
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        total++; if (bus.cmd_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", bus.cmd_valid); end
        total++; if (bus.cmd !== CMD_STAND) begin bad++; $display("FAIL b2b_cmd got=%0d want=%0d", bus.cmd, CMD_STAND); end
        total++; if (bus.cmd_dropped !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%b want=0", bus.cmd_dropped); end
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        total++; if (bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b want=0", bus.cmd_valid); end
        settle();
    endtask

    task automatic test_reset_mid();
        key_hit_n = 1'b0;
        repeat (8) tick();
        key_hit_n = 1'b1; key_deal_n = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        total++; if (bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", bus.cmd_valid); end
        total++; if (bus.cmd !== CMD_NONE) begin bad++; $display("FAIL rst_mid_cmd got=%0d want=%0d", bus.cmd, CMD_NONE); end
        total++; if (bus.buttons_held !== 3'b000) begin bad++; $display("FAIL rst_mid_held got=%b want=000", bus.buttons_held); end
        tick(); tick();
        reset = 1'b0;
        repeat (7) tick();
        total++; if (bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_deal_early got=%b want=0", bus.cmd_valid); end
        tick();
        total++; if (bus.cmd_valid !== 1'b1) begin bad++; $display("FAIL rst_deal_valid got=%b want=1", bus.cmd_valid); end
        total++; if (bus.cmd !== CMD_DEAL) begin bad++; $display("FAIL rst_deal_cmd got=%0d want=%0d", bus.cmd, CMD_DEAL); end
        bus.cmd_ready = 1'b1;
        tick();
        settle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_hit_hold();
        test_bounce();
        test_simultaneous();
        test_pending_drop();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
